// File: rtl/ex_lsu_stage.sv
// ex_lsu_stage
//   EX pipeline slot for the data-SRAM request side of the load/store unit.
//   Registers the ID payload, forms addr = base + offset, flags misaligned
//   half/word accesses (ALE), builds size/wstrb/wdata and runs the req/addr_ok
//   handshake. Requests whose instruction is flushed after issue become orphans.
//   Their data_ok responses are counted off here so MEM can ignore them.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   csr_reset              synchronous pipeline flush
//   mem_ex                 MEM holds an excepting/ertn instr; no new requests
//   ID_to_EX_valid         upstream valid
//   EX_allow_in            EX can accept a new instruction
//   MEM_allow_in           downstream ready
//   EX_to_MEM_valid        EX instruction is ready to pass to MEM
//   in_pc/base/offset/st_data, in_op   ID payload; in_op = {ld,st,size,signed,ex_prev,pad}
//   out_pc, out_addr       registered pc, effective address
//   out_ex_ALE             misaligned half/word access
//   out_mem_en             instruction owns an issued request (MEM waits data_ok)
//   data_sram_*            SRAM-like request channel
//   drop_data_ok           orphan responses outstanding; MEM must ignore data_ok
module ex_lsu_stage #(
  parameter int unsigned DROP_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_reset,
  input  logic        mem_ex,
  input  logic        ID_to_EX_valid,
  output logic        EX_allow_in,
  input  logic        MEM_allow_in,
  output logic        EX_to_MEM_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_base,
  input  logic [31:0] in_offset,
  input  logic [31:0] in_st_data,
  input  logic [6:0]  in_op,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic        out_ex_ALE,
  output logic        out_mem_en,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        drop_data_ok
);

  typedef enum logic [1:0] {StIdle, StWait, StSent, StCancel} state_e;

  localparam logic [DROP_W-1:0] DropOne = {{(DROP_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DropMax = {DROP_W{1'b1}};

  // Payload registers
  logic              ex_valid_q, ex_valid_d;
  logic [31:0]       pc_q, addr_q, st_data_q;
  logic              op_ld_q, op_st_q, op_ex_prev_q;
  logic [1:0]        op_size_q;
  logic              capture;

  state_e            state_q, state_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              drop_inc, drop_dec;

  logic              is_half, is_word, ale, need;
  logic              sram_req, hs_own, ready_go;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;

  // Signed-load and pad bits belong to MEM's result formatting, not to this stage.
  logic unused_op;
  assign unused_op = ^{in_op[2], in_op[0]};

  // ---------------------------------------------------------------------------
  // Decode of the held instruction
  // ---------------------------------------------------------------------------
  assign is_half = (op_size_q == 2'd1);
  assign is_word = (op_size_q == 2'd2);
  assign ale     = (op_ld_q | op_st_q) &
                   ((is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00)));
  assign need    = ex_valid_q & (op_ld_q | op_st_q) & ~ale & ~op_ex_prev_q;

  always_comb begin
    wstrb = 4'b0000;
    wdata = st_data_q;
    case (op_size_q)
      2'd0: begin
        wstrb = 4'b0001 << addr_q[1:0];
        wdata = {4{st_data_q[7:0]}};
      end
      2'd1: begin
        wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data_q[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = st_data_q;
      end
    endcase
    if (!op_st_q) begin
      wstrb = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Request handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_req = 1'b0;
    case (state_q)
      StIdle:   sram_req = need & ~mem_ex & ~csr_reset;
      // Once raised, req is held until addr_ok, even if the instr was flushed.
      StWait:   sram_req = 1'b1;
      StCancel: sram_req = 1'b1;
      default:  sram_req = 1'b0;
    endcase
  end

  // An addr_ok in CANCEL belongs to the orphan, never to the instr in EX.
  assign hs_own   = sram_req & data_sram_addr_ok & ((state_q == StIdle) | (state_q == StWait));
  assign ready_go = ~need | (state_q == StSent) | hs_own;

  assign EX_to_MEM_valid = ex_valid_q & ready_go;
  // While an orphan request is still pending, its address/data come from the
  // payload registers, so nothing new may be captured until it is accepted.
  assign EX_allow_in     = (state_q != StCancel) & (~ex_valid_q | (ready_go & MEM_allow_in));
  assign capture         = ID_to_EX_valid & EX_allow_in;

  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (sram_req) begin
          if (data_sram_addr_ok) begin
            // Handshake and pass-down in the same cycle keeps the slot in IDLE.
            state_d = MEM_allow_in ? StIdle : StSent;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_sram_addr_ok) begin
          if (csr_reset) begin
            state_d  = StIdle;
            drop_inc = 1'b1;
          end else begin
            state_d = MEM_allow_in ? StIdle : StSent;
          end
        end else if (csr_reset) begin
          state_d = StCancel;
        end
      end
      StCancel: begin
        if (data_sram_addr_ok) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end
      end
      StSent: begin
        if (csr_reset) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end else if (MEM_allow_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Orphan response counter
  // ---------------------------------------------------------------------------
  assign drop_dec = data_sram_data_ok & (drop_cnt_q != '0);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec) begin
      drop_cnt_d = drop_cnt_q + DropOne;
    end else if (!drop_inc && drop_dec) begin
      drop_cnt_d = drop_cnt_q - DropOne;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid bit
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (csr_reset) begin
      ex_valid_d = 1'b0;
    end else if (EX_allow_in) begin
      ex_valid_d = ID_to_EX_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q   <= 1'b0;
      state_q      <= StIdle;
      drop_cnt_q   <= '0;
      pc_q         <= '0;
      addr_q       <= '0;
      st_data_q    <= '0;
      op_ld_q      <= 1'b0;
      op_st_q      <= 1'b0;
      op_size_q    <= 2'd0;
      op_ex_prev_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      if (capture) begin
        pc_q         <= in_pc;
        addr_q       <= in_base + in_offset;
        st_data_q    <= in_st_data;
        op_ld_q      <= in_op[6];
        op_st_q      <= in_op[5];
        op_size_q    <= in_op[4:3];
        op_ex_prev_q <= in_op[1];
      end
    end
  end

`ifndef SYNTHESIS
  // More orphans in flight than the counter can hold means responses would be misattributed.
  assert property (@(posedge clk) disable iff (!resetn)
                   !(drop_inc && !drop_dec && (drop_cnt_q == DropMax)));
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_pc          = pc_q;
  assign out_addr        = addr_q;
  assign out_ex_ALE      = ex_valid_q & ale;
  assign out_mem_en      = need;
  assign data_sram_req   = sram_req;
  assign data_sram_wr    = op_st_q;
  assign data_sram_size  = op_size_q;
  assign data_sram_wstrb = wstrb;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata;
  assign drop_data_ok    = (drop_cnt_q != '0);

endmodule

// File: tb/tb_ex_lsu_stage.sv
module tb_ex_lsu_stage;

  logic        clk;
  logic        resetn;
  logic        csr_reset;
  logic        mem_ex;
  logic        ID_to_EX_valid;
  logic        EX_allow_in;
  logic        MEM_allow_in;
  logic        EX_to_MEM_valid;
  logic [31:0] in_pc, in_base, in_offset, in_st_data;
  logic [6:0]  in_op;
  logic [31:0] out_pc, out_addr;
  logic        out_ex_ALE, out_mem_en;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        drop_data_ok;
  logic        ack_auto;

  // The SRAM model accepts a raised request whenever ack_auto is set.
  assign data_sram_addr_ok = ack_auto & data_sram_req;

  ex_lsu_stage #(.DROP_W(2)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .csr_reset        (csr_reset),
    .mem_ex           (mem_ex),
    .ID_to_EX_valid   (ID_to_EX_valid),
    .EX_allow_in      (EX_allow_in),
    .MEM_allow_in     (MEM_allow_in),
    .EX_to_MEM_valid  (EX_to_MEM_valid),
    .in_pc            (in_pc),
    .in_base          (in_base),
    .in_offset        (in_offset),
    .in_st_data       (in_st_data),
    .in_op            (in_op),
    .out_pc           (out_pc),
    .out_addr         (out_addr),
    .out_ex_ALE       (out_ex_ALE),
    .out_mem_en       (out_mem_en),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_size   (data_sram_size),
    .data_sram_wstrb  (data_sram_wstrb),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .drop_data_ok     (drop_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] data;
    logic [31:0] addr;
    logic        ale;
    logic        req;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        ale;
    logic        mem_en;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb_q[$];
  sb_t  pend;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at the falling edge: retire, flush and accept in that order.
  task automatic sb_mon();
    sb_t e;
    if (EX_to_MEM_valid && MEM_allow_in) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc 0x%0h expected no pass-down", out_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pass", {out_pc, out_addr, out_ex_ALE, out_mem_en}, e);
      end
    end
    if (csr_reset) sb_q.delete();
    if (ID_to_EX_valid && EX_allow_in && !csr_reset) sb_q.push_back(pend);
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_mon();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] data,
                         input logic exp_addr_unused, input logic exp_ale,
                         input logic exp_mem_en);
    ID_to_EX_valid = 1'b1;
    in_pc          = pc;
    in_op          = op;
    in_base        = base;
    in_offset      = off;
    in_st_data     = data;
    pend.pc        = pc;
    pend.addr      = base + off;
    pend.ale       = exp_ale;
    pend.mem_en    = exp_mem_en;
    if (exp_addr_unused) pend.addr = base + off;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   data_sram_req, 1'b0);
    chk({tag, "_tomem"}, EX_to_MEM_valid, 1'b0);
    chk({tag, "_allow"}, EX_allow_in, 1'b1);
    chk({tag, "_bus"},   {out_pc, out_addr, data_sram_wdata}, 96'h0);
    chk({tag, "_ctl"},   {out_ex_ALE, out_mem_en, data_sram_wr, data_sram_size,
                          data_sram_wstrb, drop_data_ok}, 96'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    csr_reset = 1'b0;
    mem_ex = 1'b0;
    ID_to_EX_valid = 1'b0;
    MEM_allow_in = 1'b1;
    in_pc = '0; in_base = '0; in_offset = '0; in_st_data = '0; in_op = '0;
    data_sram_data_ok = 1'b0;
    ack_auto = 1'b0;
    pend = '0;

    //           op     base          off   data          addr          ale  req size wstrb wdata
    vecs[0]  = '{7'h50, 32'h0000_1000, 32'd4, 32'hDEAD_BEEF, 32'h0000_1004, 1'b0, 1'b1, 2'd2, 4'h0, 32'hDEAD_BEEF};
    vecs[1]  = '{7'h20, 32'h0000_2000, 32'd3, 32'h1234_5678, 32'h0000_2003, 1'b0, 1'b1, 2'd0, 4'h8, 32'h7878_7878};
    vecs[2]  = '{7'h28, 32'h0000_3000, 32'd2, 32'hAABB_CCDD, 32'h0000_3002, 1'b0, 1'b1, 2'd1, 4'hC, 32'hCCDD_CCDD};
    vecs[3]  = '{7'h28, 32'h0000_2FFF, 32'd1, 32'hAABB_CCDD, 32'h0000_3000, 1'b0, 1'b1, 2'd1, 4'h3, 32'hCCDD_CCDD};
    vecs[4]  = '{7'h30, 32'hFFFF_FFFC, 32'd8, 32'h0102_0304, 32'h0000_0004, 1'b0, 1'b1, 2'd2, 4'hF, 32'h0102_0304};
    vecs[5]  = '{7'h48, 32'h0000_1000, 32'd1, 32'h0000_BEEF, 32'h0000_1001, 1'b1, 1'b0, 2'd1, 4'h0, 32'hBEEF_BEEF};
    vecs[6]  = '{7'h50, 32'h0000_1000, 32'd2, 32'h0000_0000, 32'h0000_1002, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0000_0000};
    vecs[7]  = '{7'h44, 32'h0000_1000, 32'd3, 32'h0000_00A5, 32'h0000_1003, 1'b0, 1'b1, 2'd0, 4'h0, 32'hA5A5_A5A5};
    vecs[8]  = '{7'h32, 32'h0000_4000, 32'd0, 32'h55AA_55AA, 32'h0000_4000, 1'b0, 1'b0, 2'd2, 4'hF, 32'h55AA_55AA};
    vecs[9]  = '{7'h00, 32'h0000_0010, 32'h20, 32'h0000_0011, 32'h0000_0030, 1'b0, 1'b0, 2'd0, 4'h0, 32'h1111_1111};
    vecs[10] = '{7'h20, 32'h0000_5000, 32'd0, 32'h0000_00FF, 32'h0000_5000, 1'b0, 1'b1, 2'd0, 4'h1, 32'hFFFF_FFFF};

    // Reset state
    @(posedge clk); #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // Back-to-back table: addr_ok immediate, one instruction per cycle
    ack_auto = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) begin
        load_id(32'h1C00_0000 + 32'(i * 4), vecs[i].op, vecs[i].base, vecs[i].off,
                vecs[i].data, 1'b0, vecs[i].ale, vecs[i].req);
      end else begin
        ID_to_EX_valid = 1'b0;
      end
      #2;
      if (i > 0) begin
        chk("tbl_addr",  data_sram_addr,  vecs[i-1].addr);
        chk("tbl_ale",   out_ex_ALE,      vecs[i-1].ale);
        chk("tbl_req",   data_sram_req,   vecs[i-1].req);
        chk("tbl_wr",    data_sram_wr,    vecs[i-1].op[5]);
        chk("tbl_size",  data_sram_size,  vecs[i-1].size);
        chk("tbl_wstrb", data_sram_wstrb, vecs[i-1].wstrb);
        chk("tbl_wdata", data_sram_wdata, vecs[i-1].wdata);
        chk("tbl_tomem", EX_to_MEM_valid, 1'b1);
      end
      if (i < 11) chk("tbl_allow", EX_allow_in, 1'b1);
      cycle();
    end
    #2;
    chk("tbl_idle_req", data_sram_req, 1'b0);
    cycle();

    // sb with addr_ok delayed 3 cycles: request and its fields held 4 cycles
    ack_auto = 1'b0;
    load_id(32'h1C00_0100, 7'h20, 32'h0000_6000, 32'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    cycle();
    ID_to_EX_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ack_auto = 1'b1;
      #2;
      chk("dly_req",   data_sram_req, 1'b1);
      chk("dly_addr",  data_sram_addr, 32'h0000_6003);
      chk("dly_wstrb", data_sram_wstrb, 4'b1000);
      chk("dly_wdata", data_sram_wdata, 32'h7878_7878);
      chk("dly_tomem", EX_to_MEM_valid, (k == 3));
      cycle();
    end
    ack_auto = 1'b0;
    #2;
    chk("dly_done_req", data_sram_req, 1'b0);
    cycle();

    // sw flushed in WAIT, addr_ok 2 cycles after the flush: orphan response dropped
    load_id(32'h1C00_0200, 7'h30, 32'h0000_7000, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    cycle();
    ID_to_EX_valid = 1'b0;
    #2; chk("cx_req0", data_sram_req, 1'b1);
    cycle();
    csr_reset = 1'b1;
    #2; chk("cx_req_flush", data_sram_req, 1'b1);
    cycle();
    csr_reset = 1'b0;
    #2;
    chk("cx_req_cancel", data_sram_req, 1'b1);
    chk("cx_addr_held",  data_sram_addr, 32'h0000_7000);
    chk("cx_tomem",      EX_to_MEM_valid, 1'b0);
    chk("cx_drop0",      drop_data_ok, 1'b0);
    cycle();
    ack_auto = 1'b1;
    #2; chk("cx_req_ack", data_sram_req, 1'b1);
    cycle();
    ack_auto = 1'b0;
    #2;
    chk("cx_req_off", data_sram_req, 1'b0);
    chk("cx_drop1",   drop_data_ok, 1'b1);
    cycle();
    data_sram_data_ok = 1'b1;
    #2; chk("cx_drop_hold", drop_data_ok, 1'b1);
    cycle();
    data_sram_data_ok = 1'b0;
    #2; chk("cx_drop_clr", drop_data_ok, 1'b0);
    cycle();

    // sw while MEM holds an exception: never reaches the SRAM
    ack_auto = 1'b1;
    mem_ex = 1'b1;
    load_id(32'h1C00_0300, 7'h30, 32'h0000_7100, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    cycle();
    ID_to_EX_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("mex_req",   data_sram_req, 1'b0);
      chk("mex_tomem", EX_to_MEM_valid, 1'b0);
      cycle();
    end
    csr_reset = 1'b1;
    cycle();
    csr_reset = 1'b0;
    mem_ex = 1'b0;
    #2;
    chk("mex_after_req",  data_sram_req, 1'b0);
    chk("mex_after_drop", drop_data_ok, 1'b0);
    cycle();

    // Accepted but stalled by MEM (SENT), then flushed: orphan counted
    MEM_allow_in = 1'b0;
    load_id(32'h1C00_0400, 7'h30, 32'h0000_7200, 32'd0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    cycle();
    ID_to_EX_valid = 1'b0;
    #2;
    chk("snt_req_hs", data_sram_req, 1'b1);
    chk("snt_tomem0", EX_to_MEM_valid, 1'b1);
    cycle();
    #2;
    chk("snt_req_sent", data_sram_req, 1'b0);
    chk("snt_tomem1",   EX_to_MEM_valid, 1'b1);
    csr_reset = 1'b1;
    cycle();
    csr_reset = 1'b0;
    MEM_allow_in = 1'b1;
    #2;
    chk("snt_drop1", drop_data_ok, 1'b1);
    chk("snt_tomem", EX_to_MEM_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    cycle();
    data_sram_data_ok = 1'b0;
    #2; chk("snt_drop0", drop_data_ok, 1'b0);
    cycle();

    // Asynchronous reset in the middle of WAIT
    ack_auto = 1'b0;
    load_id(32'h1C00_0500, 7'h30, 32'h0000_7300, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    cycle();
    ID_to_EX_valid = 1'b0;
    #2; chk("rst_req_wait", data_sram_req, 1'b1);
    cycle();
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    sb_q.delete();
    cycle();
    resetn = 1'b1;
    cycle();
    #2; chk("rst_after_req", data_sram_req, 1'b0);
    cycle();

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
